// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding 4-byte fetch, a one-entry
// instruction buffer toward decode, and redirect with drop of in-flight data.
module if_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        rw_valid_o,
  input  logic        rw_ready_i,
  output logic [63:0] rw_addr_o,
  output logic [1:0]  rw_size_o,
  input  logic [63:0] rw_rdata_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [63:0] inst_pc_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t      r_state;
  state_t      w_state;
  logic [63:0] r_pc;
  logic [63:0] w_pc;
  logic [63:0] r_tgt;
  logic [63:0] w_tgt;
  logic        r_drop;
  logic        w_drop;
  logic [31:0] r_inst;
  logic [31:0] w_inst;
  logic [63:0] r_ipc;
  logic [63:0] w_ipc;
  logic [63:0] w_redir;
  logic        w_unused;

  assign w_redir  = {redirect_pc_i[63:2], 2'b00};
  assign w_unused = ^redirect_pc_i[1:0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_tgt   <= 64'h0;
      r_drop  <= 1'b0;
      r_inst  <= 32'h0;
      r_ipc   <= 64'h0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_tgt   <= w_tgt;
      r_drop  <= w_drop;
      r_inst  <= w_inst;
      r_ipc   <= w_ipc;
    end
  end

  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_tgt   = r_tgt;
    w_drop  = r_drop;
    w_inst  = r_inst;
    w_ipc   = r_ipc;
    unique case (r_state)
      IDLE: begin
        w_state = REQ;
        if (redirect_i) w_pc = w_redir;
      end
      REQ: begin
        if (rw_ready_i) begin
          // A same-cycle redirect is newer than any held target
          if (r_drop || redirect_i) begin
            w_pc   = redirect_i ? w_redir : r_tgt;
            w_drop = 1'b0;
          end else begin
            w_inst  = r_pc[2] ? rw_rdata_i[63:32]
                              : rw_rdata_i[31:0];
            w_ipc   = r_pc;
            w_pc    = r_pc + 64'd4;
            w_state = HOLD;
          end
        end else if (redirect_i) begin
          w_drop = 1'b1;
          w_tgt  = w_redir;
        end
      end
      HOLD: begin
        if (redirect_i) begin
          w_pc    = w_redir;
          w_state = REQ;
        end else if (inst_ready_i) begin
          w_state = REQ;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  assign rw_valid_o   = (r_state == REQ);
  assign rw_addr_o    = r_pc;
  assign rw_size_o    = 2'b10;
  assign inst_valid_o = (r_state == HOLD);
  assign inst_o       = r_inst;
  assign inst_pc_o    = r_ipc;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios then random traffic, checked
// against a transaction-level fetch model through a scoreboard queue.
module tb_if_fetch;

  localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        rw_valid_o;
  logic        rw_ready_i;
  logic [63:0] rw_addr_o;
  logic [1:0]  rw_size_o;
  logic [63:0] rw_rdata_i;
  logic        redirect_i;
  logic [63:0] redirect_pc_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [63:0] inst_pc_o;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clock         (clock),
    .reset         (reset),
    .rw_valid_o    (rw_valid_o),
    .rw_ready_i    (rw_ready_i),
    .rw_addr_o     (rw_addr_o),
    .rw_size_o     (rw_size_o),
    .rw_rdata_i    (rw_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_ready_i  (inst_ready_i),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] inst;
    logic [63:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model: phase 0 idle, 1 request outstanding, 2 instruction buffered
  int          m_phase;
  logic [63:0] m_addr;
  logic [63:0] m_tgt;
  bit          m_poison;

  function automatic logic [63:0] memfn(input logic [63:0] a);
    logic [63:0] b;
    b = {a[63:3], 3'b000};
    if (b == RPC) return 64'h0000_0013_0000_0093;
    return {b[31:0] ^ 32'hDEAD_BEEF, b[31:0] + 32'h1357_9BDF};
  endfunction

  function automatic logic [31:0] wordof(input logic [63:0] a);
    logic [63:0] d;
    d = memfn(a);
    return a[2] ? d[63:32] : d[31:0];
  endfunction

  assign rw_rdata_i = memfn(rw_addr_o);

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (reset && inst_valid_o && inst_ready_i && !redirect_i) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_inst: got pc %h inst %h required none",
                 inst_pc_o, inst_o);
      end else begin
        e = q.pop_front();
        chk("inst", 64'(inst_o), 64'(e.inst));
        chk("inst_pc", inst_pc_o, e.pc);
      end
    end
  end

  task automatic step(input bit rst, input bit rr, input bit ir,
                      input bit rd, input logic [63:0] tgt);
    logic [63:0] al;
    exp_t        t;
    al = {tgt[63:2], 2'b00};
    chk("rw_valid", 64'(rw_valid_o), 64'(m_phase == 1));
    chk("inst_valid", 64'(inst_valid_o), 64'(m_phase == 2));
    chk("rw_addr", rw_addr_o, m_addr);
    chk("rw_size", 64'(rw_size_o), 64'd2);
    if (m_phase == 0) begin
      chk("rst_inst", 64'(inst_o), 64'd0);
      chk("rst_inst_pc", inst_pc_o, 64'd0);
    end
    if (m_phase == 2 && q.size() > 0) begin
      chk("hold_inst", 64'(inst_o), 64'(q[0].inst));
      chk("hold_pc", inst_pc_o, q[0].pc);
    end
    reset         = rst;
    rw_ready_i    = rr;
    inst_ready_i  = ir;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    if (!rst) begin
      m_phase  = 0;
      m_addr   = RPC;
      m_poison = 0;
      q.delete();
    end else begin
      case (m_phase)
        0: begin
          if (rd) m_addr = al;
          m_phase = 1;
        end
        1: begin
          if (rr) begin
            if (m_poison || rd) begin
              m_addr   = rd ? al : m_tgt;
              m_poison = 0;
            end else begin
              t.inst = wordof(m_addr);
              t.pc   = m_addr;
              q.push_back(t);
              m_addr  = m_addr + 64'd4;
              m_phase = 2;
            end
          end else if (rd) begin
            m_poison = 1;
            m_tgt    = al;
          end
        end
        default: begin
          if (rd) begin
            if (q.size() > 0) void'(q.pop_back());
            m_addr  = al;
            m_phase = 1;
          end else if (ir) begin
            m_phase = 1;
          end
        end
      endcase
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [63:0] tg;
    reset         = 1'b0;
    rw_ready_i    = 1'b0;
    inst_ready_i  = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 64'h0;
    m_phase       = 0;
    m_addr        = RPC;
    m_tgt         = 64'h0;
    m_poison      = 0;
    repeat (2) @(posedge clock);
    #1;
    step(1, 0, 0, 0, 64'h0);
    step(1, 1, 0, 0, 64'h0);
    repeat (5) step(1, 0, 0, 0, 64'h0);
    step(1, 0, 1, 0, 64'h0);
    step(1, 1, 0, 0, 64'h0);
    step(1, 0, 1, 0, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    step(0, 0, 0, 0, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    step(1, 1, 0, 0, 64'h0);
    step(1, 0, 1, 0, 64'h0);
    step(1, 0, 0, 1, 64'h8000_1000);
    step(1, 0, 0, 0, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    step(1, 1, 0, 0, 64'h0);
    step(1, 1, 0, 0, 64'h0);
    step(1, 0, 1, 1, 64'h8000_2002);
    step(1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 1, 0, 0, 64'h0);
    step(1, 1, 0, 0, 64'h0);
    step(1, 0, 1, 0, 64'h0);
    step(1, 0, 0, 0, 64'h0);
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 2))
        0: tg = {$urandom, $urandom};
        1: tg = RPC + 64'($urandom_range(0, 255));
        default: tg = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
      endcase
      step($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0,
           $urandom_range(0, 1) != 0, $urandom_range(0, 7) == 0, tg);
    end
    repeat (6) step(1, 1, 1, 0, 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0000_0000_8000_0000, address of the first fetch after reset.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous reset, active-low (reset==0 resets on the next rising clock edge).
REQ-004 rw_valid_o  output  1  fetch request to the memory arbiter's IF port.
REQ-005 rw_ready_i  input  1  arbiter completion; rw_rdata_i is valid in the same cycle.
REQ-006 rw_addr_o  output  64  fetch address, equal to the internal pc.
REQ-007 rw_size_o  output  2  access size, constant 2'b10 (4 bytes).
REQ-008 rw_rdata_i  input  64  returned aligned doubleword.
REQ-009 redirect_i  input  1  branch/jump/trap redirect request.
REQ-010 redirect_pc_i  input  64  redirect target; bits [1:0] ignored (treated as 0).
REQ-011 inst_valid_o  output  1  instruction valid toward decode.
REQ-012 inst_ready_i  input  1  decode accepts the instruction.
REQ-013 inst_o  output  32  fetched instruction.
REQ-014 inst_pc_o  output  64  pc of inst_o.

Function
REQ-015 The FSM SHALL have three states: IDLE, REQ and HOLD; pc is a 64-bit register.
REQ-016 IDLE: rw_valid_o=0, inst_valid_o=0; the next state is REQ unconditionally (one idle cycle after reset release).
REQ-017 REQ: rw_valid_o=1; rw_addr_o SHALL hold stable until the cycle rw_ready_i=1. The request is never withdrawn.
REQ-018 REQ with rw_ready_i=1 and drop=0: capture inst_o = pc[2] ? rw_rdata_i[63:32] : rw_rdata_i[31:0], capture inst_pc_o=pc, pc<=pc+4, go to HOLD; inst_valid_o=1 from the next cycle.
REQ-019 HOLD: rw_valid_o=0; inst_valid_o, inst_o and inst_pc_o SHALL stay stable until inst_ready_i=1; on that handshake, inst_valid_o<=0 and next state is REQ.
REQ-020 pc+4 SHALL wrap modulo 2^64 (0xFFFF_FFFF_FFFF_FFFC -> 0x0).
REQ-021 Redirect in IDLE: pc <= {redirect_pc_i[63:2],2'b00}; the state transition is unchanged.
REQ-022 Redirect in REQ without rw_ready_i: set the drop flag; pc, rw_valid_o and rw_addr_o are unchanged.
REQ-023 REQ with rw_ready_i=1 and either drop=1 or redirect_i=1:
- discard rw_rdata_i; no inst_valid_o is produced;
- pc <= the latest redirect target;
- clear drop; stay in REQ, so a new request issues the next cycle.
REQ-024 While drop=1, the latest redirect target SHALL be held in a separate register and pc SHALL stay unchanged; a later redirect overwrites the target.
REQ-025 Redirect in HOLD, including the same cycle as inst_ready_i=1:
- redirect wins; inst_valid_o <= 0;
- pc <= target; next state is REQ.
REQ-026 Minimum steady-state spacing SHALL be 2 cycles per instruction (REQ with immediate ready, then HOLD with immediate ready); no combinational path from rw_ready_i to rw_valid_o.

Reset
REQ-027 With reset==0 at a clock edge, the block SHALL load:
- state=IDLE, pc=RESET_PC, drop=0;
- rw_valid_o=0, inst_valid_o=0, inst_o=32'h0, inst_pc_o=64'h0;
- rw_addr_o=RESET_PC, rw_size_o=2'b10.
REQ-028 Reset during REQ or HOLD SHALL abandon the request and the buffered instruction without completing any handshake.

Verification
REQ-029 Reset, then return rdata 64'h0000_0013_0000_0093 at 0x80000000 and 0x80000004 -> inst 0x00000093 with pc 0x80000000, then inst 0x00000013 with pc 0x80000004.
REQ-030 Hold inst_ready_i=0 for 5 cycles in HOLD -> inst_valid_o, inst_o and inst_pc_o stable; rw_valid_o=0 throughout.
REQ-031 Redirect to 0x80001000 while a REQ at 0x80000004 waits 3 cycles for ready -> addr stays 0x80000004 until ready; no inst_valid; next request addr 0x80001000.
REQ-032 Redirect to 0x80002002 in HOLD together with inst_ready_i=1 -> inst_valid_o=0 next cycle; next request addr 0x80002000.
REQ-033 Redirect to 0xFFFF_FFFF_FFFF_FFFC, complete the fetch -> next request addr 0x0.
REQ-034 Drive reset=0 mid-REQ -> next cycle rw_valid_o=0 and rw_addr_o=0x80000000; fetching restarts after one IDLE cycle.
